// File: rtl/mem_stage.sv
// Memory-access pipeline stage: single-entry bundle register with an FSM that performs at most
// one data-memory load or store, then forms the final writeback data for the WB stage.
module mem_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG_BITS = 5
) (
    input  logic                 clock,
    input  logic                 reset,

    output logic                 ms_ready,
    input  logic                 ms_valid,
    input  logic [XLEN-1:0]      ms_bits_pc,
    input  logic                 ms_bits_rf_we,
    input  logic [NREG_BITS-1:0] ms_bits_rf_waddr,
    input  logic [XLEN-1:0]      ms_bits_alu_result,
    input  logic                 ms_bits_mem_re,
    input  logic                 ms_bits_mem_we,
    input  logic [1:0]           ms_bits_mem_size,
    input  logic                 ms_bits_mem_unsigned,
    input  logic [XLEN-1:0]      ms_bits_store_data,
    input  logic                 ms_bits_is_break,

    output logic                 ws_valid,
    input  logic                 ws_ready,
    output logic [XLEN-1:0]      ws_bits_pc,
    output logic                 ws_bits_rf_we,
    output logic [NREG_BITS-1:0] ws_bits_rf_waddr,
    output logic [XLEN-1:0]      ws_bits_rf_wdata,
    output logic                 ws_bits_is_break,

    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic [XLEN-1:0]      dmem_req_addr,
    output logic                 dmem_req_wen,
    output logic [XLEN-1:0]      dmem_req_wdata,
    output logic [3:0]           dmem_req_wstrb,
    input  logic                 dmem_resp_valid,
    input  logic [XLEN-1:0]      dmem_resp_rdata,
    output logic                 dmem_resp_ready
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]      pc_q, pc_d;
    logic                 rf_we_q, rf_we_d;
    logic [NREG_BITS-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      alu_q, alu_d;
    logic                 is_store_q, is_store_d;
    logic [1:0]           size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic [XLEN-1:0]      sd_q, sd_d;
    logic                 is_break_q, is_break_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;

    logic            accept;
    logic [1:0]      lane;
    logic [XLEN-1:0] rdata_shifted;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;
    logic [3:0]      store_strb;
    logic [XLEN-1:0] store_wdata;

    assign ms_ready = (state_q == StIdle) | ((state_q == StDone) & ws_ready);
    assign accept   = ms_valid & ms_ready;
    assign lane     = alu_q[1:0];

    // Store lane steering: data replicated across lanes, strobes pick the addressed bytes.
    always_comb begin
        store_strb  = 4'b1111;
        store_wdata = sd_q;
        unique case (size_q)
            2'd0: begin
                store_strb  = 4'b0001 << lane;
                store_wdata = {4{sd_q[7:0]}};
            end
            2'd1: begin
                store_strb  = lane[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{sd_q[15:0]}};
            end
            default: begin
                store_strb  = 4'b1111;
                store_wdata = sd_q;
            end
        endcase
    end

    // Load extraction from the aligned word; misaligned low bits only pick the lane.
    assign rdata_shifted = dmem_resp_rdata >> {lane, 3'b000};
    assign load_byte     = rdata_shifted[7:0];
    assign load_half     = lane[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];

    always_comb begin
        load_data = dmem_resp_rdata;
        unique case (size_q)
            2'd0: load_data = {{(XLEN-8){load_byte[7] & ~unsigned_q}}, load_byte};
            2'd1: load_data = {{(XLEN-16){load_half[15] & ~unsigned_q}}, load_half};
            default: load_data = dmem_resp_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        alu_d      = alu_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        sd_d       = sd_q;
        is_break_d = is_break_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle: ;
            StReq: begin
                if (dmem_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (dmem_resp_valid) begin
                    state_d = StDone;
                    wdata_d = is_store_q ? alu_q : load_data;
                end
            end
            StDone: begin
                if (ws_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept overrides the DONE->IDLE step so ALU ops stream without a bubble.
        if (accept) begin
            pc_d       = ms_bits_pc;
            rf_we_d    = ms_bits_rf_we;
            rf_waddr_d = ms_bits_rf_waddr;
            alu_d      = ms_bits_alu_result;
            is_store_d = ms_bits_mem_we;
            size_d     = ms_bits_mem_size;
            unsigned_d = ms_bits_mem_unsigned;
            sd_d       = ms_bits_store_data;
            is_break_d = ms_bits_is_break;
            if (ms_bits_mem_re | ms_bits_mem_we) begin
                state_d = StReq;
            end else begin
                state_d = StDone;
                wdata_d = ms_bits_alu_result;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            alu_q      <= '0;
            is_store_q <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            sd_q       <= '0;
            is_break_q <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            alu_q      <= alu_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            sd_q       <= sd_d;
            is_break_q <= is_break_d;
            wdata_q    <= wdata_d;
        end
    end

    assign dmem_req_valid  = (state_q == StReq);
    assign dmem_req_addr   = alu_q;
    assign dmem_req_wen    = is_store_q;
    assign dmem_req_wdata  = store_wdata;
    assign dmem_req_wstrb  = is_store_q ? store_strb : 4'b0000;
    assign dmem_resp_ready = (state_q == StResp);

    assign ws_valid         = (state_q == StDone);
    assign ws_bits_pc       = pc_q;
    assign ws_bits_rf_we    = rf_we_q;
    assign ws_bits_rf_waddr = rf_waddr_q;
    assign ws_bits_rf_wdata = wdata_q;
    assign ws_bits_is_break = is_break_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single transactions plus hand-written stall,
// back-to-back and reset-abort sequences.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ms_ready;
    logic        ms_valid = 1'b0;
    logic [31:0] ms_bits_pc = '0;
    logic        ms_bits_rf_we = 1'b0;
    logic [4:0]  ms_bits_rf_waddr = '0;
    logic [31:0] ms_bits_alu_result = '0;
    logic        ms_bits_mem_re = 1'b0;
    logic        ms_bits_mem_we = 1'b0;
    logic [1:0]  ms_bits_mem_size = '0;
    logic        ms_bits_mem_unsigned = 1'b0;
    logic [31:0] ms_bits_store_data = '0;
    logic        ms_bits_is_break = 1'b0;
    logic        ws_valid;
    logic        ws_ready = 1'b1;
    logic [31:0] ws_bits_pc;
    logic        ws_bits_rf_we;
    logic [4:0]  ws_bits_rf_waddr;
    logic [31:0] ws_bits_rf_wdata;
    logic        ws_bits_is_break;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_wen;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid = 1'b0;
    logic [31:0] dmem_resp_rdata = '0;
    logic        dmem_resp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clock                (clock),
        .reset                (reset),
        .ms_ready             (ms_ready),
        .ms_valid             (ms_valid),
        .ms_bits_pc           (ms_bits_pc),
        .ms_bits_rf_we        (ms_bits_rf_we),
        .ms_bits_rf_waddr     (ms_bits_rf_waddr),
        .ms_bits_alu_result   (ms_bits_alu_result),
        .ms_bits_mem_re       (ms_bits_mem_re),
        .ms_bits_mem_we       (ms_bits_mem_we),
        .ms_bits_mem_size     (ms_bits_mem_size),
        .ms_bits_mem_unsigned (ms_bits_mem_unsigned),
        .ms_bits_store_data   (ms_bits_store_data),
        .ms_bits_is_break     (ms_bits_is_break),
        .ws_valid             (ws_valid),
        .ws_ready             (ws_ready),
        .ws_bits_pc           (ws_bits_pc),
        .ws_bits_rf_we        (ws_bits_rf_we),
        .ws_bits_rf_waddr     (ws_bits_rf_waddr),
        .ws_bits_rf_wdata     (ws_bits_rf_wdata),
        .ws_bits_is_break     (ws_bits_is_break),
        .dmem_req_valid       (dmem_req_valid),
        .dmem_req_ready       (dmem_req_ready),
        .dmem_req_addr        (dmem_req_addr),
        .dmem_req_wen         (dmem_req_wen),
        .dmem_req_wdata       (dmem_req_wdata),
        .dmem_req_wstrb       (dmem_req_wstrb),
        .dmem_resp_valid      (dmem_resp_valid),
        .dmem_resp_rdata      (dmem_resp_rdata),
        .dmem_resp_ready      (dmem_resp_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic        re;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] sd;
        logic        brk;
        logic [31:0] rdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rf;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_bundle(input vec_t v);
        ms_bits_pc           = v.pc;
        ms_bits_rf_we        = v.rf_we;
        ms_bits_rf_waddr     = v.waddr;
        ms_bits_alu_result   = v.alu;
        ms_bits_mem_re       = v.re;
        ms_bits_mem_we       = v.we;
        ms_bits_mem_size     = v.size;
        ms_bits_mem_unsigned = v.uns;
        ms_bits_store_data   = v.sd;
        ms_bits_is_break     = v.brk;
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic rf_we, input logic [4:0] waddr,
                                input logic [31:0] alu, input logic re, input logic we,
                                input logic [1:0] size, input logic uns, input logic [31:0] sd,
                                input logic brk, input logic [31:0] rdata,
                                input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_rf);
        vec_t v;
        v.pc = pc; v.rf_we = rf_we; v.waddr = waddr; v.alu = alu; v.re = re; v.we = we;
        v.size = size; v.uns = uns; v.sd = sd; v.brk = brk; v.rdata = rdata;
        v.exp_strb = exp_strb; v.exp_wdata = exp_wdata; v.exp_rf = exp_rf;
        return v;
    endfunction

    // One transaction with no stalls; memory ops take exactly three cycles to reach WB.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive_bundle(v);
        ms_valid = 1'b1;
        tick();
        ms_valid = 1'b0;
        if (v.re | v.we) begin
            chk({tag, ".req_valid"}, 32'(dmem_req_valid), 32'd1);
            chk({tag, ".ms_ready_busy"}, 32'(ms_ready), 32'd0);
            chk({tag, ".req_addr"}, dmem_req_addr, v.alu);
            chk({tag, ".req_wen"}, 32'(dmem_req_wen), 32'(v.we));
            chk({tag, ".req_wstrb"}, 32'(dmem_req_wstrb), 32'(v.exp_strb));
            if (v.we) chk({tag, ".req_wdata"}, dmem_req_wdata, v.exp_wdata);
            dmem_req_ready = 1'b1;
            tick();
            dmem_req_ready = 1'b0;
            chk({tag, ".resp_ready"}, 32'(dmem_resp_ready), 32'd1);
            chk({tag, ".ws_valid_early"}, 32'(ws_valid), 32'd0);
            dmem_resp_valid = 1'b1;
            dmem_resp_rdata = v.rdata;
            tick();
            dmem_resp_valid = 1'b0;
            dmem_resp_rdata = 32'h5A5A_5A5A;
        end
        chk({tag, ".ws_valid"}, 32'(ws_valid), 32'd1);
        chk({tag, ".rf_wdata"}, ws_bits_rf_wdata, v.exp_rf);
        chk({tag, ".pc"}, ws_bits_pc, v.pc);
        chk({tag, ".rf_we"}, 32'(ws_bits_rf_we), 32'(v.rf_we));
        chk({tag, ".rf_waddr"}, 32'(ws_bits_rf_waddr), 32'(v.waddr));
        chk({tag, ".is_break"}, 32'(ws_bits_is_break), 32'(v.brk));
        tick();
        chk({tag, ".back_idle"}, 32'(ws_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] held_addr;

        //        pc            we wa  alu           re we sz u  sd            brk rdata
        //        strb     wdata          rf_wdata
        vecs[0]  = mk(32'h0000_1000, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 32'h0, 0, 32'h0,
                      4'b0000, 32'h0, 32'h0000_1234);
        vecs[1]  = mk(32'h0000_1004, 1, 6, 32'h8000_0003, 1, 0, 0, 0, 32'h0, 0, 32'h80FF_7F00,
                      4'b0000, 32'h0, 32'hFFFF_FF80);
        vecs[2]  = mk(32'h0000_1008, 1, 7, 32'h0000_0002, 1, 0, 1, 1, 32'h0, 0, 32'hBEEF_1234,
                      4'b0000, 32'h0, 32'h0000_BEEF);
        vecs[3]  = mk(32'h0000_100C, 0, 0, 32'h0000_0101, 0, 1, 0, 0, 32'h0000_00AB, 0, 32'h0,
                      4'b0010, 32'hABAB_ABAB, 32'h0000_0101);
        vecs[4]  = mk(32'h0000_1010, 1, 8, 32'h0000_0000, 1, 0, 1, 0, 32'h0, 0, 32'h1234_8001,
                      4'b0000, 32'h0, 32'hFFFF_8001);
        vecs[5]  = mk(32'h0000_1014, 1, 9, 32'h0000_0001, 1, 0, 0, 1, 32'h0, 0, 32'h0000_9A00,
                      4'b0000, 32'h0, 32'h0000_009A);
        vecs[6]  = mk(32'h0000_1018, 1, 10, 32'h0000_0004, 1, 0, 2, 0, 32'h0, 0, 32'hDEAD_BEEF,
                      4'b0000, 32'h0, 32'hDEAD_BEEF);
        vecs[7]  = mk(32'h0000_101C, 0, 0, 32'h0000_0202, 0, 1, 1, 0, 32'h1234_5678, 0, 32'h0,
                      4'b1100, 32'h5678_5678, 32'h0000_0202);
        vecs[8]  = mk(32'h0000_1020, 0, 0, 32'h0000_0300, 0, 1, 2, 0, 32'hCAFE_F00D, 0, 32'h0,
                      4'b1111, 32'hCAFE_F00D, 32'h0000_0300);
        vecs[9]  = mk(32'h0000_1024, 0, 0, 32'h0000_0003, 1, 1, 0, 0, 32'h0000_0011, 0,
                      32'hFFFF_FFFF, 4'b1000, 32'h1111_1111, 32'h0000_0003);
        vecs[10] = mk(32'h0000_1028, 1, 11, 32'h0000_0001, 1, 0, 0, 0, 32'h0, 1, 32'h0000_7F00,
                      4'b0000, 32'h0, 32'h0000_007F);
        vecs[11] = mk(32'h0000_102C, 1, 12, 32'h0000_0007, 1, 0, 3, 0, 32'h0, 0, 32'h0102_0304,
                      4'b0000, 32'h0, 32'h0102_0304);

        tick();
        tick();
        chk("rst.ms_ready", 32'(ms_ready), 32'd1);
        chk("rst.ws_valid", 32'(ws_valid), 32'd0);
        chk("rst.req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst.resp_ready", 32'(dmem_resp_ready), 32'd0);
        chk("rst.rf_wdata", ws_bits_rf_wdata, 32'd0);
        chk("rst.pc", ws_bits_pc, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle.ws_valid", 32'(ws_valid), 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back ALU bundles: one per cycle with ws_ready held high.
        ws_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v = mk(32'h2000 + 32'(4 * i), 1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0, 32'h0,
                   0, 32'h0, 4'b0, 32'h0, 32'h0);
            drive_bundle(v);
            ms_valid = 1'b1;
            tick();
            chk($sformatf("b2b%0d.ws_valid", i), 32'(ws_valid), 32'd1);
            chk($sformatf("b2b%0d.rf_wdata", i), ws_bits_rf_wdata, 32'h100 + 32'(i));
            chk($sformatf("b2b%0d.ms_ready", i), 32'(ms_ready), 32'd1);
        end
        ms_valid = 1'b0;
        tick();
        chk("b2b.drain", 32'(ws_valid), 32'd0);

        // Request stall, plus a response offered on the request handshake edge (must be ignored).
        v = mk(32'h3000, 1, 3, 32'h0000_0010, 1, 0, 2, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0);
        drive_bundle(v);
        ms_valid = 1'b1;
        tick();
        ms_valid = 1'b0;
        held_addr = 32'h0000_0010;
        ms_bits_alu_result = 32'hFFFF_FFF0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstall%0d.req_valid", i), 32'(dmem_req_valid), 32'd1);
            chk($sformatf("rstall%0d.addr", i), dmem_req_addr, held_addr);
            chk($sformatf("rstall%0d.ms_ready", i), 32'(ms_ready), 32'd0);
        end
        dmem_req_ready  = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hBAD0_BAD0;
        tick();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        chk("early_resp.resp_ready", 32'(dmem_resp_ready), 32'd1);
        tick();
        chk("resp_wait.ws_valid", 32'(ws_valid), 32'd0);
        chk("resp_wait.resp_ready", 32'(dmem_resp_ready), 32'd1);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h600D_F00D;
        tick();
        dmem_resp_valid = 1'b0;
        chk("rstall.ws_valid", 32'(ws_valid), 32'd1);
        chk("rstall.rf_wdata", ws_bits_rf_wdata, 32'h600D_F00D);
        tick();

        // WB backpressure: bundle held, new bundle waits.
        v = mk(32'h4000, 1, 4, 32'h0000_AAAA, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0);
        drive_bundle(v);
        ms_valid = 1'b1;
        tick();
        ws_ready = 1'b0;
        v = mk(32'h4004, 1, 9, 32'h0000_BBBB, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0);
        drive_bundle(v);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("wstall%0d.ms_ready", i), 32'(ms_ready), 32'd0);
            tick();
            chk($sformatf("wstall%0d.ws_valid", i), 32'(ws_valid), 32'd1);
            chk($sformatf("wstall%0d.rf_wdata", i), ws_bits_rf_wdata, 32'h0000_AAAA);
            chk($sformatf("wstall%0d.pc", i), ws_bits_pc, 32'h4000);
        end
        ws_ready = 1'b1;
        tick();
        ms_valid = 1'b0;
        chk("wstall.next_wdata", ws_bits_rf_wdata, 32'h0000_BBBB);
        chk("wstall.next_waddr", 32'(ws_bits_rf_waddr), 32'd9);
        tick();

        // Reset while waiting for a response; the late response must not surface.
        v = mk(32'h5000, 1, 2, 32'h0000_0020, 1, 0, 2, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0);
        drive_bundle(v);
        ms_valid = 1'b1;
        tick();
        ms_valid = 1'b0;
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("rstmid.in_resp", 32'(dmem_resp_ready), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.ws_valid", 32'(ws_valid), 32'd0);
        chk("rstmid.req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rstmid.resp_ready", 32'(dmem_resp_ready), 32'd0);
        chk("rstmid.ms_ready", 32'(ms_ready), 32'd1);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h1357_9BDF;
        tick();
        dmem_resp_valid = 1'b0;
        chk("late.ws_valid", 32'(ws_valid), 32'd0);
        chk("late.resp_ready", 32'(dmem_resp_ready), 32'd0);
        tick();
        chk("late.ws_valid2", 32'(ws_valid), 32'd0);
        chk("late.rf_wdata", ws_bits_rf_wdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, between the EX stage and the WB stage.
- Accepts one instruction bundle per handshake from EX.
- Performs at most one data-memory load or store through a valid/ready request/response port, then forms the final writeback data and presents the bundle to the WB stage.
- Single-entry, FSM-controlled; non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 32, datapath and address width.
- NREG_BITS, 5, register-file address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ms_ready  out  1  stage can accept a bundle from EX
- ms_valid  in  1  EX bundle valid
- ms_bits_pc  in  32  instruction PC
- ms_bits_rf_we  in  1  register write enable
- ms_bits_rf_waddr  in  5  destination register
- ms_bits_alu_result  in  32  memory address, or writeback value for non-memory instructions
- ms_bits_mem_re  in  1  load
- ms_bits_mem_we  in  1  store
- ms_bits_mem_size  in  2  0=byte, 1=half, 2/3=word
- ms_bits_mem_unsigned  in  1  zero-extend load
- ms_bits_store_data  in  32  raw store data (rs2)
- ms_bits_is_break  in  1  ebreak marker
- ws_valid  out  1  bundle valid to WB
- ws_ready  in  1  WB accepts
- ws_bits_pc / ws_bits_rf_we / ws_bits_rf_waddr / ws_bits_rf_wdata / ws_bits_is_break  out  32/1/5/32/1  bundle to WB
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  32  byte address (= alu_result, unaligned bits kept)
- dmem_req_wen  out  1  1=store
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_wstrb  out  4  byte strobes (0 for loads)
- dmem_resp_valid  in  1  response valid
- dmem_resp_rdata  in  32  aligned word read
- dmem_resp_ready  out  1  stage accepts response

Behaviour:
- Clocking: one clock; reset is synchronous and active-high; all state updates on the rising edge of clock.
- FSM states: IDLE, REQ, RESP, DONE.
- Reset:
  - state=IDLE; the bundle register and wdata register clear to 0.
  - ws_valid=0, dmem_req_valid=0, dmem_resp_ready=0, ms_ready=1.
- ms_ready = (state==IDLE) | (state==DONE & ws_ready).
- Accept: occurs when ms_valid & ms_ready.
  - The bundle is latched.
  - If mem_we|mem_re, next state is REQ; otherwise next state is DONE with wdata=alu_result.
  - If mem_we and mem_re are both set, the instruction is a store.
- REQ:
  - dmem_req_valid=1; request fields are driven from the latched bundle and held stable until dmem_req_ready.
  - On dmem_req_ready, next state is RESP.
- RESP:
  - dmem_resp_ready=1.
  - On dmem_resp_valid, next state is DONE.
  - Loads latch the extracted data; stores latch wdata=alu_result.
  - Stores also wait for a response (write ack).
- DONE:
  - ws_valid=1 and ws_bits are driven from registers.
  - On ws_ready with no new accept, next state is IDLE.
  - On ws_ready with simultaneous ms_valid, the accept path applies in the same cycle (zero bubble for ALU ops).
  - While ws_ready=0, ws_bits hold and no new bundle is taken.
- Store lanes (a = addr[1:0]):
  - Byte: wstrb = 1<<a, wdata = {4{sd[7:0]}}.
  - Half: wstrb = a[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - Word: wstrb = 1111, wdata = sd.
- Load extraction:
  - Byte: rdata[8a+7:8a].
  - Half: rdata[16*a[1]+15:16*a[1]].
  - Word: full rdata.
  - Sign-extend unless mem_unsigned.
- Misalignment: misaligned half/word accesses are not trapped; the low address bits are ignored beyond the lane selection above.
- Response timing:
  - A response arriving in the same cycle as the request is not accepted; the response is taken only in RESP.
  - dmem_resp_valid outside RESP is ignored.
- Reset mid-transaction: the transaction is abandoned immediately, with no WB output; a late response after reset is ignored because IDLE holds dmem_resp_ready=0.
- is_break, pc, rf_we and rf_waddr pass through unchanged.
- Latency from accept to ws_valid:
  - Non-memory: 1 cycle.
  - Memory: 1 + request wait + response wait cycles; minimum 3 cycles.

Test Plan:
- ALU pass-through: ms_valid with alu_result=0x1234, rf_waddr=5, rf_we=1, ws_ready=1 -> ws_valid the next cycle, rf_wdata=0x1234; back-to-back bundles sustain 1 per cycle.
- Signed byte load:
  - Stimulus: lb at addr 0x80000003, dmem_resp_rdata=0x80FF7F00.
  - Request: dmem_req_wstrb=0, dmem_req_addr=0x80000003.
  - Result: rf_wdata=0xFFFFFF80.
- Unsigned half load: lhu at addr 0x2, rdata=0xBEEF1234 -> rf_wdata=0x0000BEEF.
- Byte store:
  - Stimulus: sb at addr 0x101, store_data=0x000000AB.
  - Result: wstrb=0010, wdata=0xABABABAB, wen=1; ws_valid only after the response.
- Stalls:
  - dmem_req_ready low for 3 cycles -> the request is held stable and ms_ready=0.
  - ws_ready low for 2 cycles in DONE -> ws_bits are stable and no new accept occurs.
- Reset mid-op:
  - Stimulus: assert reset in RESP, then pulse dmem_resp_valid after reset.
  - Result: state=IDLE, ws_valid=0, dmem_req_valid=0; the late response is ignored and no WB output appears.
